// File: rtl/ca_uart_dump.sv
// rtl/ca_uart_dump.sv - Streams each new automaton generation as one ASCII row over UART TX (8N1).
// A row is WIDTH cell characters, MSB first, then CR LF; only the latest generation queues behind a busy row.
module ca_uart_dump #(
    parameter int         WIDTH     = 128,
    parameter int         BAUD_DIV  = 104,
    parameter logic [7:0] ONE_CHAR  = 8'h23,
    parameter logic [7:0] ZERO_CHAR = 8'h2E
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    output logic             tx,
    output logic             busy,
    output logic             overrun
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(WIDTH + 2);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] IDX_CR    = IW'(WIDTH);
    localparam logic [IW-1:0] IDX_LF    = IW'(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] row_q, row_d;
    logic             pending_q, pending_d;
    logic             first_q, first_d;
    logic             overrun_q, overrun_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic             change;
    logic             baud_end;
    logic [WIDTH-1:0] row_shifted;
    logic [7:0]       cur_char;

    assign change      = (data != data_q);
    assign baud_end    = (baud_q == BAUD_LAST);
    // Shifting left by the index puts the current cell at the MSB.
    assign row_shifted = row_q << idx_q;

    always_comb begin
        cur_char = row_shifted[WIDTH-1] ? ONE_CHAR : ZERO_CHAR;
        if (idx_q == IDX_CR) begin
            cur_char = 8'h0D;
        end else if (idx_q == IDX_LF) begin
            cur_char = 8'h0A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            row_q     <= '0;
            pending_q <= 1'b0;
            first_q   <= 1'b1;
            overrun_q <= 1'b0;
            baud_q    <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data;
            row_q     <= row_d;
            pending_q <= pending_d;
            first_q   <= first_d;
            overrun_q <= overrun_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // tx_d always carries the level of the bit that starts at the next edge.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        pending_d = pending_q;
        first_d   = first_q;
        overrun_d = overrun_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                if (first_q || pending_q || change) begin
                    row_d     = data;
                    first_d   = 1'b0;
                    pending_d = 1'b0;
                    idx_d     = '0;
                    baud_d    = '0;
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = cur_char[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_char[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q != IDX_LF) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A second change before the queued one is sent means a generation was dropped.
        if (state_q != IDLE && change) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end
            pending_d = 1'b1;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_ca_uart_dump.sv
// tb/tb_ca_uart_dump.sv - Self-checking bench for ca_uart_dump (WIDTH=8, BAUD_DIV=4).
module tb_ca_uart_dump;
    localparam int W    = 8;
    localparam int BD   = 4;
    localparam int NCH  = W + 2;
    localparam int ROWC = NCH * 10 * BD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       tx, busy, overrun;

    int checks = 0;
    int errors = 0;

    logic       smp [ROWC];
    logic [7:0] got [NCH];
    logic       row_timeout, row_glitch, row_frame, busy_all, busy_after;
    logic       exp_ovr;

    ca_uart_dump #(
        .WIDTH(W),
        .BAUD_DIV(BD),
        .ONE_CHAR(8'h23),
        .ZERO_CHAR(8'h2E)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data(data),
        .tx(tx),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_char(input logic [7:0] v, input int i);
        logic [7:0] t;
        t = v >> (W - 1 - i);
        if (i < W) return t[0] ? 8'h23 : 8'h2E;
        else if (i == W) return 8'h0D;
        else return 8'h0A;
    endfunction

    function automatic logic [7:0] diff(input logic [7:0] p);
        logic [7:0] r;
        r = 8'($urandom);
        if (r == p) r = ~p;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a start bit, records the whole row at one sample per cycle, then decodes it.
    task automatic capture_row();
        int n = 0;
        row_timeout = 1'b0;
        row_glitch  = 1'b0;
        row_frame   = 1'b0;
        busy_all    = 1'b1;
        busy_after  = 1'b1;
        @(negedge clk);
        while (tx !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            row_timeout = 1'b1;
            return;
        end
        for (int k = 0; k < ROWC; k++) begin
            smp[k] = tx;
            if (busy !== 1'b1) busy_all = 1'b0;
            if (k < ROWC - 1) @(negedge clk);
        end
        @(negedge clk);
        busy_after = busy;
        for (int c = 0; c < NCH; c++) begin
            logic [7:0] b;
            b = '0;
            for (int bi = 0; bi < 10; bi++) begin
                int  j;
                logic bitv;
                j = (c * 10 + bi) * BD;
                for (int q = 1; q < BD; q++) begin
                    if (smp[j+q] !== smp[j]) row_glitch = 1'b1;
                end
                bitv = smp[j + BD/2];
                if (bi == 0 && bitv !== 1'b0) row_frame = 1'b1;
                if (bi == 9 && bitv !== 1'b1) row_frame = 1'b1;
                if (bi >= 1 && bi <= 8) b = {bitv, b[7:1]};
            end
            got[c] = b;
        end
    endtask

    task automatic check_row(input string tag, input logic [7:0] v);
        chk({tag, "_timeout"}, 8'(row_timeout), 8'd0);
        chk({tag, "_bitlen"}, 8'(row_glitch), 8'd0);
        chk({tag, "_frame"}, 8'(row_frame), 8'd0);
        chk({tag, "_busy_during"}, 8'(busy_all), 8'd1);
        chk({tag, "_busy_after"}, 8'(busy_after), 8'd0);
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("%s_char%0d", tag, i), got[i], exp_char(v, i));
        end
        chk({tag, "_overrun"}, 8'(overrun), 8'(exp_ovr));
    endtask

    // One row of v0, with n changes landing mid-row; the next row must carry the last change.
    task automatic row_pair(input string tag, input logic [7:0] v0, input logic [7:0] chg [3], input int n);
        data = v0;
        fork
            capture_row();
            begin
                for (int k = 0; k < n; k++) begin
                    repeat ($urandom_range(100, 20)) @(negedge clk);
                    data = chg[k];
                end
            end
        join
        if (n >= 2) exp_ovr = 1'b1;
        check_row({tag, "_a"}, v0);
        capture_row();
        check_row({tag, "_b"}, chg[n-1]);
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        logic ok;
        ok = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk(tag, 8'(ok), 8'd1);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] c [3];
        int         n;

        exp_ovr = 1'b0;
        repeat (16) begin
            @(negedge clk);
            data = 8'($urandom);
            chk("rst_tx", 8'(tx), 8'd1);
            chk("rst_busy", 8'(busy), 8'd0);
            chk("rst_overrun", 8'(overrun), 8'd0);
        end

        @(negedge clk);
        data = 8'h81;
        rst  = 1'b0;
        capture_row();
        check_row("basic", 8'h81);

        check_quiet("no_change", 2000);

        v = diff(8'h81);
        if (v == 8'h0F) v = 8'h55;
        row_pair("one", v, '{8'h0F, 8'h00, 8'h00}, 1);
        check_quiet("one_after", 50);

        for (int r = 0; r < 4; r++) begin
            v    = diff(data);
            c[0] = diff(v);
            c[1] = diff(c[0]);
            c[2] = diff(c[1]);
            n    = $urandom_range(3, 1);
            row_pair($sformatf("rnd%0d", r), v, c, n);
            check_quiet($sformatf("rnd%0d_after", r), 20);
        end

        v = diff(data);
        while (v == 8'h01) v = diff(data);
        row_pair("two", v, '{8'h01, 8'hF0, 8'h00}, 2);
        check_quiet("two_after", 100);
        chk("two_overrun_sticky", 8'(overrun), 8'd1);

        v    = diff(data);
        data = v;
        n    = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_start", 8'(tx), 8'd0);
        repeat (130) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_tx", 8'(tx), 8'd1);
        chk("rstmid_busy", 8'(busy), 8'd0);
        chk("rstmid_overrun", 8'(overrun), 8'd0);
        exp_ovr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        capture_row();
        check_row("rstmid_row", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ca_uart_dump.md
# ca_uart_dump

Downstream consumer of the cellular automaton's generation vector. Each time `data` changes to a new generation, the block snapshots it and streams it over a UART TX line as one ASCII text row: one character per cell, MSB (leftmost cell) first, terminated by CR LF. This lets a serial terminal display the automaton's evolution live on hardware.

## Interface
- `WIDTH`, 128: number of cells. Must match the automaton's `WIDTH`.
- `BAUD_DIV`, 104: clock cycles per UART bit (12 MHz / 115200). Must be ≥ 2.
- `ONE_CHAR`, 8'h23: character for a live cell ('#').
- `ZERO_CHAR`, 8'h2E: character for a dead cell ('.').

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: asynchronous, active-high reset.
- `data`  in  WIDTH: current automaton generation. Synchronous to `clk`.
- `tx`  out  1: UART serial output, 8N1, idle high.
- `busy`  out  1: high while a row is being transmitted.
- `overrun`  out  1: sticky flag, set when an intermediate generation was never transmitted.

## Operation
- Reset values: `tx`=1, `busy`=0, `overrun`=0; state IDLE; `data_q`=0; `pending`=0; `first`=1.
- Change detect:
  - `data_q` registers `data` every cycle.
  - `change` = (`data` != `data_q`).
- FSM states: IDLE, START, DATA, STOP.
- IDLE, when any of `first`, `pending` or `change` is set:
  - load row buffer `buf` <= `data`;
  - clear `first` and `pending`;
  - set char index to 0;
  - go to START.
- While in any non-IDLE state, on `change`:
  - if `pending`=1, set `overrun`=1;
  - set `pending`=1.
  - As a result, only the latest generation is sent after the current row.
- Character at index i:
  - i < WIDTH: `buf[WIDTH-1-i]` ? `ONE_CHAR` : `ZERO_CHAR`;
  - i = WIDTH: 8'h0D;
  - i = WIDTH+1: 8'h0A.
- UART frame per character:
  - START: `tx`=0;
  - DATA: 8 bits, LSB first;
  - STOP: `tx`=1.
- End of STOP:
  - if i < WIDTH+1: increment i and go to START (back-to-back characters, no idle gap);
  - else go to IDLE.
- Counter widths:
  - baud counter: $clog2(BAUD_DIV);
  - bit counter: 3 bits;
  - char index: $clog2(WIDTH+2).
  - No counter may wrap mid-frame.
- `overrun` clears only on `rst`.

## Timing
- `tx` and `busy` are registered outputs.
- Trigger seen in IDLE at cycle t → at t+1, `tx`=0 (start bit) and `busy`=1.
- Every bit, including start and stop, is held exactly `BAUD_DIV` cycles.
- A row lasts (WIDTH+2) × 10 × `BAUD_DIV` cycles, from the `tx` falling edge to the end of the last stop bit.
- `busy` falls in the cycle the FSM re-enters IDLE. IDLE lasts at least 1 cycle between rows.
- First row after reset: `first`=1 forces a trigger in the first clock edge after `rst` deasserts. The captured value is `data` at that edge.
- `change` in the same cycle IDLE loads: the loaded value is the current `data`; `pending` is not set.
- Reset mid-operation: `tx` goes to 1 and `busy` to 0 immediately (asynchronous). The partial row is abandoned. A fresh full row starts after release.

## Test plan
Use `WIDTH`=8 and `BAUD_DIV`=4 unless stated.
- **Reset:** hold `rst`=1 with `data` toggling → `tx`=1, `busy`=0, `overrun`=0 throughout.
- **Basic row:** release reset with `data`=8'b1000_0001 held stable → decoded bytes are 23 2E 2E 2E 2E 2E 2E 23 0D 0A. `busy` stays high for exactly 400 cycles. Each bit lasts 4 cycles.
- **No change:** `data` held constant for 2000 cycles after the first row → no further start bit; `busy`=0.
- **One change while busy:** change `data` once to 8'h0F mid-row → after the current row, exactly one row 2E 2E 2E 2E 23 23 23 23 0D 0A follows; `overrun`=0.
- **Two changes while busy:** change `data` to 8'h01, then 8'hF0, during one row → the next row shows 8'hF0 only, and `overrun`=1 persists until reset.
- **Reset mid-row:** assert `rst` during the DATA bits of character 3 → `tx`=1 with no clock edge required. After release, a complete 10-character row of the current `data` is sent.
